// File: rtl/autocat_way_allocator.sv
// rtl/autocat_way_allocator.sv - hit-profile driven contiguous way-mask suggester
// Profiles hits per LRU stack position over an epoch, then picks the fewest low-order ways covering the goal.
module autocat_way_allocator #(
  parameter int NUM_WAY       = 16,
  parameter int EPOCH_LEN     = 1024,
  parameter int COUNTER_WIDTH = 16,
  parameter int GOAL_SHIFT    = 3
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               access_valid_in,
  input  logic [NUM_WAY-1:0] hit_vec_in,
  output logic [NUM_WAY-1:0] suggested_waymask_out
);

  localparam int ACC_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam int IDX_W = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
  localparam int K_W   = $clog2(NUM_WAY + 1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_COUNT, S_EVAL, S_UPDATE} state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ACC_W-1:0]         r_acc_cnt;
  logic [COUNTER_WIDTH-1:0] r_cnt [NUM_WAY];
  logic [COUNTER_WIDTH-1:0] r_total;
  logic [COUNTER_WIDTH-1:0] r_cum;
  logic [IDX_W-1:0]         r_idx;
  logic [K_W-1:0]           r_k;
  logic                     r_k_found;
  logic [NUM_WAY-1:0]       r_mask;

  logic                     w_hit;
  logic [IDX_W-1:0]         w_hit_idx;
  logic                     w_epoch_end;
  logic                     w_eval_last;
  logic                     w_count_en;
  logic                     w_eval_en;
  logic                     w_update_en;
  logic [COUNTER_WIDTH:0]   w_cum_sum;
  logic [COUNTER_WIDTH-1:0] w_cum_next;
  logic [COUNTER_WIDTH-1:0] w_uncovered;
  logic [COUNTER_WIDTH-1:0] w_tolerance;
  logic                     w_goal_met;
  logic [NUM_WAY-1:0]       w_new_mask;

  assign suggested_waymask_out = r_mask;

  // Only the closest-to-MRU hit position is credited.
  always_comb begin
    w_hit_idx = '0;
    for (int b = NUM_WAY - 1; b >= 0; b--) begin
      if (hit_vec_in[b]) w_hit_idx = IDX_W'(b);
    end
  end

  assign w_hit       = |hit_vec_in;
  assign w_epoch_end = (r_acc_cnt == ACC_W'(EPOCH_LEN - 1));
  assign w_eval_last = (r_idx == IDX_W'(NUM_WAY - 1));

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) r_state <= S_COUNT;
    else           r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_COUNT:  if (access_valid_in && w_epoch_end) w_next_state = S_EVAL;
      S_EVAL:   if (w_eval_last) w_next_state = S_UPDATE;
      S_UPDATE: w_next_state = S_COUNT;
      default:  w_next_state = S_COUNT;
    endcase
  end

  always_comb begin
    w_count_en  = (r_state == S_COUNT) && access_valid_in;
    w_eval_en   = (r_state == S_EVAL);
    w_update_en = (r_state == S_UPDATE);
  end

  assign w_cum_sum   = {1'b0, r_cum} + {1'b0, r_cnt[r_idx]};
  assign w_cum_next  = w_cum_sum[COUNTER_WIDTH] ? CNT_MAX : w_cum_sum[COUNTER_WIDTH-1:0];
  // Saturated per-position counters can sum past total; treat that as fully covered.
  assign w_uncovered = (w_cum_next >= r_total) ? '0 : (r_total - w_cum_next);
  assign w_tolerance = r_total >> GOAL_SHIFT;
  assign w_goal_met  = (w_uncovered <= w_tolerance);

  always_comb begin
    w_new_mask = '0;
    for (int b = 0; b < NUM_WAY; b++) begin
      w_new_mask[b] = (b < int'(r_k));
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_acc_cnt <= '0;
      for (int p = 0; p < NUM_WAY; p++) r_cnt[p] <= '0;
      r_total   <= '0;
      r_cum     <= '0;
      r_idx     <= '0;
      r_k       <= '0;
      r_k_found <= 1'b0;
      r_mask    <= '1;
    end else begin
      if (w_count_en) begin
        r_acc_cnt <= w_epoch_end ? '0 : (r_acc_cnt + 1'b1);
        if (w_hit) begin
          if (r_cnt[w_hit_idx] != CNT_MAX) r_cnt[w_hit_idx] <= r_cnt[w_hit_idx] + 1'b1;
          if (r_total != CNT_MAX)          r_total <= r_total + 1'b1;
        end
        if (w_epoch_end) begin
          r_idx     <= '0;
          r_cum     <= '0;
          r_k       <= '0;
          r_k_found <= 1'b0;
        end
      end
      if (w_eval_en) begin
        r_cum <= w_cum_next;
        r_idx <= w_eval_last ? '0 : (r_idx + 1'b1);
        if (!r_k_found && w_goal_met) begin
          r_k       <= K_W'(r_idx) + 1'b1;
          r_k_found <= 1'b1;
        end else if (!r_k_found && w_eval_last) begin
          r_k       <= K_W'(NUM_WAY);
          r_k_found <= 1'b1;
        end
      end
      if (w_update_en) begin
        if (r_total != '0) r_mask <= w_new_mask;
        for (int p = 0; p < NUM_WAY; p++) r_cnt[p] <= '0;
        r_total <= '0;
      end
    end
  end

endmodule

// File: tb/tb_autocat_way_allocator.sv
// tb/tb_autocat_way_allocator.sv - directed self-checking bench for autocat_way_allocator
// Each task drives one scenario and checks the mask value and its exact update timing.
module tb_autocat_way_allocator;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        access_valid_in = 1'b0;
  logic [15:0] hit_vec_in = '0;
  logic [15:0] suggested_waymask_out;

  int n_vec = 0;
  int n_err = 0;

  autocat_way_allocator #(
    .NUM_WAY(16), .EPOCH_LEN(1024), .COUNTER_WIDTH(16), .GOAL_SHIFT(3)
  ) dut (
    .clk_in               (clk_in),
    .reset_in             (reset_in),
    .access_valid_in      (access_valid_in),
    .hit_vec_in           (hit_vec_in),
    .suggested_waymask_out(suggested_waymask_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic drive(input logic [15:0] vec, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      access_valid_in = 1'b1;
      hit_vec_in      = vec;
    end
  endtask

  // Called right after the epoch's last access is driven; edge E0 follows.
  task automatic finish_epoch(input string name, input logic [15:0] old_m, input logic [15:0] new_m,
                              input logic ev_valid, input logic [15:0] ev_vec);
    @(negedge clk_in);
    access_valid_in = ev_valid;
    hit_vec_in      = ev_vec;
    repeat (16) @(negedge clk_in);
    n_vec++;
    if (suggested_waymask_out !== old_m) begin
      n_err++;
      $display("FAIL %s_before_E17: got %h expected %h", name, suggested_waymask_out, old_m);
    end
    @(negedge clk_in);
    n_vec++;
    if (suggested_waymask_out !== new_m) begin
      n_err++;
      $display("FAIL %s_after_E17: got %h expected %h", name, suggested_waymask_out, new_m);
    end
    access_valid_in = 1'b0;
    hit_vec_in      = '0;
  endtask

  task automatic test_reset;
    reset_in = 1'b0;
    repeat (3) @(negedge clk_in);
    n_vec++;
    if (suggested_waymask_out !== 16'hFFFF) begin
      n_err++;
      $display("FAIL reset_mask: got %h expected %h", suggested_waymask_out, 16'hFFFF);
    end
    reset_in = 1'b1;
    @(negedge clk_in);
  endtask

  task automatic test_all_miss(input logic [15:0] cur);
    drive(16'h0000, 1024);
    finish_epoch("all_miss", cur, cur, 1'b0, 16'h0000);
  endtask

  task automatic test_mru;
    drive(16'h0001, 1024);
    finish_epoch("mru", 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
  endtask

  task automatic test_uniform;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk_in);
      access_valid_in = 1'b1;
      hit_vec_in      = 16'h0001 << (i % 16);
    end
    finish_epoch("uniform", 16'h0001, 16'h3FFF, 1'b0, 16'h0000);
  endtask

  // Exactly at tolerance 128 covers with one way; one more uncovered hit needs six.
  task automatic test_tolerance_edge;
    drive(16'h0001, 896);
    drive(16'h0020, 128);
    finish_epoch("tol_exact", 16'h3FFF, 16'h0001, 1'b0, 16'h0000);
    drive(16'h0001, 895);
    drive(16'h0020, 129);
    finish_epoch("tol_over", 16'h0001, 16'h003F, 1'b0, 16'h0000);
  endtask

  task automatic test_multi_bit_eval_ignore;
    drive(16'h0006, 1024);
    finish_epoch("multi_bit", 16'h003F, 16'h0003, 1'b1, 16'h0001);
    drive(16'h0004, 1024);
    finish_epoch("post_eval", 16'h0003, 16'h0007, 1'b0, 16'h0000);
  endtask

  task automatic test_mid_epoch_reset;
    drive(16'h0001, 500);
    @(negedge clk_in);
    access_valid_in = 1'b0;
    reset_in        = 1'b0;
    #1;
    n_vec++;
    if (suggested_waymask_out !== 16'hFFFF) begin
      n_err++;
      $display("FAIL mid_epoch_reset: got %h expected %h", suggested_waymask_out, 16'hFFFF);
    end
    @(negedge clk_in);
    reset_in = 1'b1;
    drive(16'h0008, 1024);
    finish_epoch("after_reset", 16'hFFFF, 16'h000F, 1'b0, 16'h0000);
  endtask

  task automatic test_mid_eval_reset;
    drive(16'h0001, 1024);
    @(negedge clk_in);
    access_valid_in = 1'b0;
    repeat (4) @(negedge clk_in);
    reset_in = 1'b0;
    #1;
    n_vec++;
    if (suggested_waymask_out !== 16'hFFFF) begin
      n_err++;
      $display("FAIL mid_eval_reset: got %h expected %h", suggested_waymask_out, 16'hFFFF);
    end
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (20) @(negedge clk_in);
    n_vec++;
    if (suggested_waymask_out !== 16'hFFFF) begin
      n_err++;
      $display("FAIL eval_discarded: got %h expected %h", suggested_waymask_out, 16'hFFFF);
    end
    drive(16'h0002, 1024);
    finish_epoch("after_eval_reset", 16'hFFFF, 16'h0003, 1'b0, 16'h0000);
  endtask

  task automatic test_last_way;
    drive(16'h8000, 1024);
    finish_epoch("last_way", 16'h0003, 16'hFFFF, 1'b0, 16'h0000);
  endtask

  task automatic test_idle;
    int changes;
    changes = 0;
    drive(16'h0001, 1024);
    finish_epoch("pre_idle", 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk_in);
      access_valid_in = 1'b0;
      hit_vec_in      = 16'($urandom_range(1, 16'hFFFF));
      if (suggested_waymask_out !== 16'h0001) changes++;
    end
    n_vec++;
    if (changes != 0) begin
      n_err++;
      $display("FAIL idle_mask: %0d cycles changed, expected 0", changes);
    end
    drive(16'h0004, 1024);
    finish_epoch("after_idle", 16'h0001, 16'h0007, 1'b0, 16'h0000);
  endtask

  initial begin
    test_reset();
    test_all_miss(16'hFFFF);
    test_mru();
    test_uniform();
    test_tolerance_edge();
    test_all_miss(16'h003F);
    test_multi_bit_eval_ignore();
    test_mid_epoch_reset();
    test_mid_eval_reset();
    test_last_way();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
